demux_1_4_dispatch: RTL and testbench
=====================================

Name: demux_1_4_dispatch

Overview:
- Sequencing controller for the 1:4 demux datapath: accepts a valid/ready input stream and steers each beat to one of four output channels.
- Routing is either directed by a per-beat destination field or round-robin among the channels that can accept.
- Each channel has a one-entry registered holding slot, so downstream backpressure on one channel does not corrupt another.
- Sits between a single producer and four consumers. It replaces free-running select lines with a handshaked scheduler.

Parameters:
- DATA_W, 8: payload width per beat.
- CNT_W, 16: width of the accepted-beat counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = directed (use in_dest), 1 = round-robin.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  dispatcher can accept the beat this cycle.
- in_data  input  DATA_W  beat payload.
- in_dest  input  2  target channel in directed mode; ignored in round-robin mode.
- out_valid  output  4  bit k: slot k holds a beat.
- out_ready  input  4  bit k: consumer k takes the beat this cycle.
- out_data  output  4*DATA_W  slot k payload at bits [k*DATA_W +: DATA_W].
- sel  output  2  channel of the most recently accepted beat.
- beat_cnt  output  CNT_W  total accepted beats, saturating.

Behaviour:
- Reset (clk edge with rst=1):
  - out_valid=0, out_data=0, sel=0, beat_cnt=0, round-robin pointer rr_ptr=0.
  - Held beats are discarded; this also applies when reset lands mid-stream.
- Slot k can accept when out_valid[k]==0 || out_ready[k].
- Target selection (combinational, same cycle):
  - Directed: target = in_dest. in_ready = can_accept[in_dest].
  - Round-robin: scan channels rr_ptr, rr_ptr+1, ... mod 4; target = first channel that can accept. in_ready = any channel can accept.
  - in_ready does not depend on in_valid.
- Accept = in_valid && in_ready. On accept:
  - slot[target] loads in_data and out_valid[target]=1.
  - sel=target.
  - beat_cnt increments, holding at all-ones with no wrap.
  - In round-robin mode only, rr_ptr = target+1 mod 4 (3 wraps to 0).
- Drain: out_valid[k] && out_ready[k] with no load into k that cycle -> out_valid[k]=0. out_data[k] holds its last value.
- Drain and load of the same slot in one cycle: new beat loaded, out_valid stays 1. Full throughput of 1 beat/clk per channel.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N.
- Mode:
  - mode is sampled every cycle with no idle requirement.
  - rr_ptr is not modified in directed mode and is not cleared on mode change.
- No duplication: at most one slot loads per cycle. No beat is dropped or reordered within a channel.
- out_ready[k] while out_valid[k]==0 is ignored.
- Outputs out_valid, out_data, sel and beat_cnt are registered. in_ready is combinational from out_valid, out_ready, mode, in_dest and rr_ptr.

Decomposition:
- Shared package demux_pkg:
  - NUM_CH=4, CH_W=2.
  - Mode constants MODE_DIRECTED=1'b0, MODE_RR=1'b1.
  - A function for the round-robin first-available search.
- Sub-module demux_slot: one-entry holding register with load/drain/valid logic and DATA_W parameter. It is instantiated 4 times.
- Top level holds target selection, rr_ptr, sel and beat_cnt.

Test Plan:
- Reset then idle: rst=1 for 2 clks -> out_valid=0000, beat_cnt=0, sel=0, in_ready=1 in both modes.
- Directed, out_ready=1111: send data 0x11,0x22,0x33,0x44 with dest 0,1,2,3 -> after each edge exactly one out_valid bit set, out_data slot k = value, sel=k, beat_cnt=4.
- Directed backpressure: out_ready=0000, send 0xA5 to dest 2, then 0x5A to dest 2 -> in_ready=0 on the 2nd beat and slot 2 holds 0xA5. Raise out_ready[2] -> 0x5A loads in that same edge, out_valid[2] stays 1.
- Round-robin: mode=1, out_ready=1111, 6 beats back-to-back -> channels 0,1,2,3,0,1, rr_ptr=2 at end.
- Round-robin skip: mode=1, slots 0 and 1 full with out_ready=0, rr_ptr=0 -> next beat goes to channel 2, sel=2, rr_ptr=3. With all four full and out_ready=0000 -> in_ready=0.
- Reset mid-operation: slots 1 and 3 full, beat_cnt=7, rst=1 for one clk -> out_valid=0000, beat_cnt=0, rr_ptr=0, and the next beat in round-robin goes to channel 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants, types and the round-robin search used by the 1:4 dispatcher.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic MODE_DIRECTED = 1'b0;
  localparam logic MODE_RR       = 1'b1;

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] ch;
  } rr_pick_t;

  // First channel at or after ptr (wrapping mod NUM_CH) whose avail bit is set.
  function automatic rr_pick_t rr_first_avail(input logic [NUM_CH-1:0] avail,
                                              input logic [CH_W-1:0]   ptr);
    rr_pick_t        r;
    logic [CH_W-1:0] c;
    r.found = 1'b0;
    r.ch    = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      c = ptr + CH_W'(i);
      if (!r.found && avail[c]) begin
        r.found = 1'b1;
        r.ch    = c;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  // A load wins over a drain in the same cycle, giving one beat per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_4_dispatch.sv
// 1:4 dispatcher: steers a valid/ready stream into four registered channel slots.
// Handshake: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
module demux_1_4_dispatch
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [CH_W-1:0]          in_dest,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CH_W-1:0]          sel,
  output logic [CNT_W-1:0]         beat_cnt
);

  logic [NUM_CH-1:0] can_accept;
  logic [NUM_CH-1:0] load;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   target;
  logic              accept;
  rr_pick_t          pick;

  assign can_accept = ~out_valid | out_ready;

  always_comb begin
    pick     = rr_first_avail(can_accept, rr_ptr);
    target   = in_dest;
    in_ready = can_accept[in_dest];
    if (mode == MODE_RR) begin
      target   = pick.ch;
      in_ready = pick.found;
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept) load[target] = 1'b1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[k]),
      .drain (out_ready[k]),
      .d     (in_data),
      .valid (out_valid[k]),
      .q     (out_data[k*DATA_W +: DATA_W])
    );
  end

  // rr_ptr only advances on round-robin accepts, so directed traffic leaves it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel      <= '0;
      beat_cnt <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      sel <= target;
      if (beat_cnt != {CNT_W{1'b1}}) beat_cnt <= beat_cnt + CNT_W'(1);
      if (mode == MODE_RR) rr_ptr <= target + CH_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_1_4_dispatch.sv
// Table-driven bench for demux_1_4_dispatch with per-channel scoreboard queues.
module tb_demux_1_4_dispatch;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic                mode;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_dest;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [4*DATA_W-1:0] out_data;
  logic [1:0]          sel;
  logic [CNT_W-1:0]    beat_cnt;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q [4][$];

  typedef struct {
    logic              rst;
    logic              mode;
    logic              in_valid;
    logic [1:0]        dest;
    logic [DATA_W-1:0] data;
    logic [3:0]        rdy;
    logic              exp_ready;
    logic [1:0]        exp_ch;
    logic [3:0]        exp_valid;
    logic [1:0]        exp_sel;
    logic [CNT_W-1:0]  exp_cnt;
  } vec_t;

  vec_t tbl[$];

  demux_1_4_dispatch #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel),
    .beat_cnt  (beat_cnt)
  );

  // clock
  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int m, input int v, input int dst,
                              input int dat, input int rdy, input int er, input int ch,
                              input int ev, input int es, input int ec);
    vec_t x;
    x.rst       = r[0];
    x.mode      = m[0];
    x.in_valid  = v[0];
    x.dest      = dst[1:0];
    x.data      = dat[DATA_W-1:0];
    x.rdy       = rdy[3:0];
    x.exp_ready = er[0];
    x.exp_ch    = ch[1:0];
    x.exp_valid = ev[3:0];
    x.exp_sel   = es[1:0];
    x.exp_cnt   = ec[CNT_W-1:0];
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [DATA_W-1:0] e;
    @(negedge clk);
    rst       = v.rst;
    mode      = v.mode;
    in_valid  = v.in_valid;
    in_dest   = v.dest;
    in_data   = v.data;
    out_ready = v.rdy;
    #1;
    chk($sformatf("row%0d in_ready", idx), 32'(in_ready), 32'(v.exp_ready));
    if (!v.rst) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("row%0d ch%0d unexpected drain", idx, k), 32'(1), 32'(0));
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("row%0d ch%0d drain data", idx, k),
                32'(out_data[k*DATA_W +: DATA_W]), 32'(e));
          end
        end
      end
      if (v.in_valid && v.exp_ready) exp_q[v.exp_ch].push_back(v.data);
    end
    @(posedge clk);
    #1;
    if (v.rst) for (int k = 0; k < 4; k++) exp_q[k].delete();
    chk($sformatf("row%0d out_valid", idx), 32'(out_valid), 32'(v.exp_valid));
    chk($sformatf("row%0d sel", idx), 32'(sel), 32'(v.exp_sel));
    chk($sformatf("row%0d beat_cnt", idx), 32'(beat_cnt), 32'(v.exp_cnt));
    for (int k = 0; k < 4; k++) begin
      if (v.exp_valid[k] && exp_q[k].size() > 0)
        chk($sformatf("row%0d ch%0d held data", idx, k),
            32'(out_data[k*DATA_W +: DATA_W]), 32'(exp_q[k][0]));
    end
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int                ec;

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_dest = '0; in_data = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'(0));
    chk("reset out_data", out_data, 32'(0));
    chk("reset sel", 32'(sel), 32'(0));
    chk("reset beat_cnt", 32'(beat_cnt), 32'(0));

    //             rst m v dst dat    rdy  er ch ev    es cnt
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 'h0, 1, 0, 'h0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 'h00, 'h0, 1, 0, 'h0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 'h11, 'hF, 1, 0, 'h1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 'h22, 'hF, 1, 1, 'h2, 1, 2));
    tbl.push_back(mk(0, 0, 1, 2, 'h33, 'hF, 1, 2, 'h4, 2, 3));
    tbl.push_back(mk(0, 0, 1, 3, 'h44, 'hF, 1, 3, 'h8, 3, 4));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 'hF, 1, 0, 'h0, 3, 4));
    // directed backpressure on channel 2
    tbl.push_back(mk(0, 0, 1, 2, 'hA5, 'h0, 1, 2, 'h4, 2, 5));
    tbl.push_back(mk(0, 0, 1, 2, 'h5A, 'h0, 0, 2, 'h4, 2, 5));
    tbl.push_back(mk(0, 0, 1, 2, 'h5A, 'h4, 1, 2, 'h4, 2, 6));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 'h4, 1, 0, 'h0, 2, 6));
    // round-robin, everything ready
    tbl.push_back(mk(0, 1, 1, 3, 'h60, 'hF, 1, 0, 'h1, 0, 7));
    tbl.push_back(mk(0, 1, 1, 3, 'h61, 'hF, 1, 1, 'h2, 1, 8));
    tbl.push_back(mk(0, 1, 1, 3, 'h62, 'hF, 1, 2, 'h4, 2, 9));
    tbl.push_back(mk(0, 1, 1, 3, 'h63, 'hF, 1, 3, 'h8, 3, 10));
    tbl.push_back(mk(0, 1, 1, 3, 'h64, 'hF, 1, 0, 'h1, 0, 11));
    tbl.push_back(mk(0, 1, 1, 3, 'h65, 'hF, 1, 1, 'h2, 1, 12));
    tbl.push_back(mk(0, 1, 1, 0, 'h66, 'hF, 1, 2, 'h4, 2, 13));
    tbl.push_back(mk(0, 1, 1, 0, 'h67, 'hF, 1, 3, 'h8, 3, 14));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 'hF, 1, 0, 'h0, 3, 14));
    // fill slots 0,1 directed, then round-robin skips to 2 and 3
    tbl.push_back(mk(0, 0, 1, 0, 'h70, 'h0, 1, 0, 'h1, 0, 15));
    tbl.push_back(mk(0, 0, 1, 1, 'h71, 'h0, 1, 1, 'h3, 1, 16));
    tbl.push_back(mk(0, 1, 1, 0, 'h72, 'h0, 1, 2, 'h7, 2, 17));
    tbl.push_back(mk(0, 1, 1, 0, 'h73, 'h0, 1, 3, 'hF, 3, 18));
    tbl.push_back(mk(0, 1, 1, 0, 'h74, 'h0, 0, 0, 'hF, 3, 18));
    tbl.push_back(mk(0, 0, 1, 1, 'h74, 'h0, 0, 1, 'hF, 3, 18));
    tbl.push_back(mk(0, 1, 1, 0, 'h75, 'h4, 1, 2, 'hF, 2, 19));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 'hF, 1, 0, 'h0, 2, 19));
    // reset, then move rr_ptr and leave slots 1 and 3 full before a mid-stream reset
    tbl.push_back(mk(1, 0, 0, 0, 'h00, 'h0, 1, 0, 'h0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 'h80, 'hF, 1, 0, 'h1, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 'h81, 'hF, 1, 1, 'h2, 1, 2));
    tbl.push_back(mk(0, 1, 1, 0, 'h82, 'hF, 1, 2, 'h4, 2, 3));
    tbl.push_back(mk(0, 1, 1, 0, 'h83, 'hF, 1, 3, 'h8, 3, 4));
    tbl.push_back(mk(0, 1, 1, 0, 'h84, 'hF, 1, 0, 'h1, 0, 5));
    tbl.push_back(mk(0, 0, 1, 1, 'h85, 'h1, 1, 1, 'h2, 1, 6));
    tbl.push_back(mk(0, 0, 1, 3, 'h86, 'h1, 1, 3, 'hA, 3, 7));
    tbl.push_back(mk(1, 1, 0, 0, 'h00, 'h0, 1, 0, 'h0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 'h90, 'h0, 1, 0, 'h1, 0, 1));

    foreach (tbl[i]) apply(tbl[i], i);

    // saturation: continuous round-robin traffic past the counter ceiling
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      rst       = 1'b0;
      mode      = 1'b1;
      in_valid  = 1'b1;
      out_ready = 4'hF;
      d         = DATA_W'($urandom_range(0, 255));
      in_data   = d;
      #1;
      chk($sformatf("sat%0d in_ready", i), 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;
      ec = (i + 1 > 63) ? 63 : i + 1;
      chk($sformatf("sat%0d beat_cnt", i), 32'(beat_cnt), 32'(ec));
      chk($sformatf("sat%0d sel", i), 32'(sel), 32'(i % 4));
      chk($sformatf("sat%0d data", i), 32'(out_data[(i % 4)*DATA_W +: DATA_W]), 32'(d));
    end
    @(negedge clk);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
